// File: rtl/float_minmax_scanner_if.sv
// Operand-stream handshake and result bundle for float_minmax_scanner.
// The master drives start/len/elements; the slave returns status and running extremes.
interface float_minmax_scanner_if #(
   parameter int unsigned LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             empty;
   logic [31:0]      max_val;
   logic [31:0]      min_val;
   logic [LEN_W-1:0] max_idx;
   logic [LEN_W-1:0] min_idx;

   modport master (
      output start, len, in_valid, in_data,
      input  in_ready, busy, done, empty, max_val, min_val, max_idx, min_idx
   );

   modport slave (
      input  start, len, in_valid, in_data,
      output in_ready, busy, done, empty, max_val, min_val, max_idx, min_idx
   );
endinterface

// File: rtl/float_minmax_scanner.sv
// Streams a block of single-precision words, one per cycle, tracking the running
// maximum and minimum (FloatCompare ordering) and the index where each first occurred.
module float_minmax_scanner #(
   parameter int unsigned LEN_W = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   float_minmax_scanner_if.slave  io_bus
);

   typedef enum logic [1:0] {StIdle, StFirst, StScan, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [31:0]      r_max_val;
   logic [31:0]      r_min_val;
   logic [LEN_W-1:0] r_max_idx;
   logic [LEN_W-1:0] r_min_idx;
   logic             r_busy;
   logic             r_empty;
   logic             w_len_zero;
   logic             w_last;
   logic             w_in_ready;
   logic             w_done;
   logic             w_accept;
   logic             w_new_max;
   logic             w_new_min;

   // Sign-magnitude ordering; -0 ranks below +0 because only bitwise equality ties.
   function automatic logic f_ge(input logic [31:0] a, input logic [31:0] b);
      logic res;
      if (a == b) begin
         res = 1'b1;
      end else if (a[31] != b[31]) begin
         res = ~a[31];
      end else if (a[30:23] != b[30:23]) begin
         res = a[31] ? (a[30:23] < b[30:23]) : (a[30:23] > b[30:23]);
      end else begin
         res = a[31] ? (a[22:0] < b[22:0]) : (a[22:0] > b[22:0]);
      end
      return res;
   endfunction

   function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
      return f_ge(a, b) && (a != b);
   endfunction

   assign w_len_zero = (r_len == '0);
   assign w_last     = (r_cnt == r_len - LEN_W'(1));
   assign w_accept   = w_in_ready && io_bus.in_valid;
   assign w_new_max  = f_gt(io_bus.in_data, r_max_val);
   assign w_new_min  = f_gt(r_min_val, io_bus.in_data);

   // An empty block idles one cycle in StFirst (no element taken) so done lands two
   // cycles after start, matching the upstream sequencer's timing.
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_done       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_bus.start) w_state_next = StFirst;
         end
         StFirst: begin
            if (w_len_zero) begin
               w_state_next = StDone;
            end else begin
               w_in_ready = 1'b1;
               if (io_bus.in_valid) begin
                  w_state_next = (r_len == LEN_W'(1)) ? StDone : StScan;
               end
            end
         end
         StScan: begin
            w_in_ready = 1'b1;
            if (io_bus.in_valid && w_last) w_state_next = StDone;
         end
         StDone: begin
            w_done       = 1'b1;
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_len     <= '0;
         r_cnt     <= '0;
         r_max_val <= '0;
         r_min_val <= '0;
         r_max_idx <= '0;
         r_min_idx <= '0;
         r_busy    <= 1'b0;
         r_empty   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.start) begin
                  r_len   <= io_bus.len;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_empty <= 1'b0;
               end
            end
            StFirst: begin
               if (w_len_zero) begin
                  r_empty   <= 1'b1;
                  r_max_val <= '0;
                  r_min_val <= '0;
                  r_max_idx <= '0;
                  r_min_idx <= '0;
               end else if (w_accept) begin
                  r_max_val <= io_bus.in_data;
                  r_min_val <= io_bus.in_data;
                  r_max_idx <= '0;
                  r_min_idx <= '0;
                  r_cnt     <= LEN_W'(1);
               end
            end
            StScan: begin
               if (w_accept) begin
                  if (w_new_max) begin
                     r_max_val <= io_bus.in_data;
                     r_max_idx <= r_cnt;
                  end
                  if (w_new_min) begin
                     r_min_val <= io_bus.in_data;
                     r_min_idx <= r_cnt;
                  end
                  r_cnt <= r_cnt + LEN_W'(1);
               end
            end
            StDone: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.in_ready = w_in_ready;
   assign io_bus.busy     = r_busy;
   assign io_bus.done     = w_done;
   assign io_bus.empty    = r_empty;
   assign io_bus.max_val  = r_max_val;
   assign io_bus.min_val  = r_min_val;
   assign io_bus.max_idx  = r_max_idx;
   assign io_bus.min_idx  = r_min_idx;

endmodule

// File: tb/tb_float_minmax_scanner.sv
// Randomised bench for float_minmax_scanner: floats are mapped to an order-preserving
// unsigned key and the first index of the largest/smallest key is the reference answer.
module tb_float_minmax_scanner;
   localparam int unsigned LEN_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   float_minmax_scanner_if #(.LEN_W(LEN_W)) bus ();

   float_minmax_scanner #(.LEN_W(LEN_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Total order: positives above negatives, magnitudes sorted; -0 just below +0.
   function automatic logic [31:0] order_key(input logic [31:0] f);
      return f[31] ? ~f : {1'b1, f[30:0]};
   endfunction

   function automatic logic [31:0] rand_float();
      logic [31:0] v;
      case ($urandom_range(3))
         0: v = $urandom;
         1: begin
            case ($urandom_range(7))
               0: v = 32'h0000_0000;
               1: v = 32'h8000_0000;
               2: v = 32'h3f80_0000;
               3: v = 32'hbf80_0000;
               4: v = 32'h4000_0000;
               5: v = 32'hc000_0000;
               6: v = 32'h7f80_0000;
               default: v = 32'hff80_0000;
            endcase
         end
         2: v = {1'($urandom_range(1)), 8'h80, 20'h0, 3'($urandom_range(7))};
         default: v = {1'($urandom_range(1)), 8'($urandom_range(126, 129)), 23'h0};
      endcase
      return v;
   endfunction

   task automatic check_results(input string pfx, input logic [31:0] emax, input logic [31:0] emin,
                                input int emaxi, input int emini, input logic eempty);
      check_val({pfx, "_max_val"}, bus.max_val, emax);
      check_val({pfx, "_min_val"}, bus.min_val, emin);
      check_val({pfx, "_max_idx"}, bus.max_idx, emaxi);
      check_val({pfx, "_min_idx"}, bus.min_idx, emini);
      check_val({pfx, "_empty"}, bus.empty, eempty);
   endtask

   // Inputs change on the falling edge; outputs are read there too, away from posedge.
   task automatic do_scan(input logic [31:0] d[$], input int stall_pct, input int vpat);
      int          n = d.size();
      int          idx = 0;
      int          cyc = 0;
      int          max_i = 0;
      int          min_i = 0;
      logic [31:0] emax = '0;
      logic [31:0] emin = '0;
      for (int i = 1; i < n; i++) begin
         if (order_key(d[i]) > order_key(d[max_i])) max_i = i;
         if (order_key(d[i]) < order_key(d[min_i])) min_i = i;
      end
      if (n > 0) begin
         emax = d[max_i];
         emin = d[min_i];
      end
      @(negedge clk);
      bus.start    = 1'b1;
      bus.len      = LEN_W'(n);
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      check_val("busy_on", bus.busy, 1);
      check_val("empty_clr", bus.empty, 0);
      if (n == 0) begin
         check_val("ready_len0", bus.in_ready, 0);
         check_val("done_early_len0", bus.done, 0);
         @(negedge clk);
      end
      while (idx < n && cyc < 20 * n + 20) begin
         check_val("ready", bus.in_ready, 1);
         check_val("done_early", bus.done, 0);
         check_val("busy_mid", bus.busy, 1);
         if (vpat != 0 && cyc < 8) bus.in_valid = vpat[cyc];
         else bus.in_valid = ($urandom_range(99) >= stall_pct);
         bus.in_data = bus.in_valid ? d[idx] : $urandom;
         bus.start   = ($urandom_range(3) == 0);
         bus.len     = LEN_W'($urandom);
         if (bus.in_valid) idx++;
         @(negedge clk);
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      if (idx < n) check_val("timeout_accepts", idx, n);
      check_val("done", bus.done, 1);
      check_val("busy_at_done", bus.busy, 1);
      check_val("ready_at_done", bus.in_ready, 0);
      check_results("res", emax, emin, max_i, min_i, n == 0);
      // start coincident with done must be dropped
      bus.start = 1'b1;
      bus.len   = LEN_W'($urandom_range(1, 9));
      @(negedge clk);
      bus.start = 1'b0;
      check_val("done_one_cycle", bus.done, 0);
      check_val("busy_after_done", bus.busy, 0);
      check_val("ready_idle", bus.in_ready, 0);
      check_results("hold", emax, emin, max_i, min_i, n == 0);
   endtask

   initial begin
      logic [31:0] q[$];
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_ready", bus.in_ready, 0);
      check_results("rst", '0, '0, 0, 0, 1'b0);
      rst_n = 1'b1;

      q = {32'h3f80_0000, 32'hc000_0000, 32'h4040_0000, 32'h0000_0000};
      do_scan(q, 0, 0);
      q = {32'h4000_0000, 32'h4000_0000, 32'h3f80_0000};
      do_scan(q, 0, 0);
      q = {32'h8000_0000, 32'h0000_0000};
      do_scan(q, 0, 0);
      q = {32'h4000_0000, 32'h3f80_0000, 32'hbf80_0000};
      do_scan(q, 0, 6'b101001);
      q = {};
      do_scan(q, 0, 0);

      // Reset abandons a scan part way through.
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = LEN_W'(5);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = rand_float();
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("rst2_busy", bus.busy, 0);
      check_val("rst2_ready", bus.in_ready, 0);
      check_val("rst2_done", bus.done, 0);
      check_results("rst2", '0, '0, 0, 0, 1'b0);
      q = {32'hc120_0000};
      do_scan(q, 0, 0);

      repeat (25) begin
         int n = $urandom_range(0, 12);
         q = {};
         for (int i = 0; i < n; i++) q.push_back(rand_float());
         do_scan(q, $urandom_range(0, 60), 0);
      end

      q = {};
      for (int i = 0; i < 255; i++) q.push_back(rand_float());
      do_scan(q, 10, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
